// File: rtl/mux_pkg.sv
// Shared types and helpers for the 4:1 round-robin collector.
package mux_pkg;

   localparam int unsigned N_CH = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Next channel index, wrapping 3 -> 0.
   function automatic sel_t next_idx(input sel_t i);
      return sel_t'(i + 2'd1);
   endfunction

endpackage : mux_pkg

// File: rtl/mux_4to1_rr_collector_rr_arb4.sv
// Combinational 4-way round-robin picker: search starts one past the last winner.
module rr_arb4
   import mux_pkg::*;
(
   input  logic [N_CH-1:0] in_valid,
   input  sel_t            last,
   input  logic            en,
   output logic [N_CH-1:0] grant_oh,
   output sel_t            grant_idx,
   output logic            any
);

   logic found;
   sel_t idx;

   // Walk last+1, last+2, last+3, last and take the first requester.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      idx       = last;
      for (int j = 0; j < int'(N_CH); j++) begin
         idx = next_idx(idx);
         if (!found && in_valid[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
   end

   // A grant only exists when the output side can take a word.
   always_comb begin
      any      = en && found;
      grant_oh = any ? (4'b0001 << grant_idx) : 4'b0000;
   end

endmodule : rr_arb4

// File: rtl/mux_4to1_rr_collector.sv
// Four request channels merged into one registered stream tagged with its source index.
module mux_4to1_rr_collector
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  in_valid,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   output logic [N_CH-1:0]  in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output sel_t             out_sel,
   input  logic             out_ready
);

   state_t           state;
   sel_t             last;
   logic             load_en;
   logic             arb_en;
   logic [N_CH-1:0]  grant_oh;
   sel_t             grant_idx;
   logic             any;
   logic [WIDTH-1:0] mux_data;

   assign out_valid = (state == ST_FULL);

   // Output register can be refilled when empty or draining this cycle.
   assign load_en = !out_valid || out_ready;

   // Nothing is accepted while reset is held.
   assign arb_en = load_en && rst_n;

   rr_arb4 u_arb (
      .in_valid  (in_valid),
      .last      (last),
      .en        (arb_en),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any       (any)
   );

   assign in_ready = grant_oh;

   // Data select driven by the arbiter index.
   always_comb begin
      mux_data = '0;
      case (grant_idx)
         2'd0:    mux_data = in_data0;
         2'd1:    mux_data = in_data1;
         2'd2:    mux_data = in_data2;
         default: mux_data = in_data3;
      endcase
   end

   // EMPTY/FULL output stage plus priority pointer; pointer moves only on accepted words.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_EMPTY;
         out_data <= '0;
         out_sel  <= '0;
         last     <= 2'd3;
      end else if (load_en) begin
         if (any) begin
            state    <= ST_FULL;
            out_data <= mux_data;
            out_sel  <= grant_idx;
            last     <= grant_idx;
         end else begin
            state    <= ST_EMPTY;
         end
      end
   end

endmodule : mux_4to1_rr_collector

// File: tb/tb_mux_4to1_rr_collector.sv
// Directed bench for the 4:1 round-robin collector.
module tb_mux_4to1_rr_collector;

   logic       clk;
   logic       rst_n;
   logic [3:0] in_valid;
   logic [7:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0] in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic [1:0] out_sel;
   logic       out_ready;

   int n_pass  = 0;
   int n_total = 0;

   mux_4to1_rr_collector #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_data2  (in_data2),
      .in_data3  (in_data3),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_total++;
         if (in_ready !== 4'b0000) $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
         else n_pass++;
      end
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      else n_pass++;
      n_total++;
      if (out_sel !== 2'd0) $display("FAIL reset_out_sel: got %0d expected 0", out_sel);
      else n_pass++;
      n_total++;
      if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", out_data);
      else n_pass++;
      rst_n = 1'b1;
      in_valid = 4'b0000;
      #1;
   endtask

   task automatic test_single();
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 4'b0100) $display("FAIL single_in_ready: got %b expected 0100", in_ready);
      else n_pass++;
      tick();
      in_valid = 4'b0000;
      #1;
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2)
         $display("FAIL single_out: got v=%b d=%h s=%0d expected v=1 d=a5 s=2", out_valid, out_data, out_sel);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_sel !== 2'd2)
         $display("FAIL single_drain_hold: got v=%b d=%h s=%0d expected v=0 d=a5 s=2", out_valid, out_data, out_sel);
      else n_pass++;
   endtask

   task automatic test_rotation();
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h10; exp_d[1] = 8'h21; exp_d[2] = 8'h32; exp_d[3] = 8'h43;
      in_data0 = 8'h10; in_data1 = 8'h21; in_data2 = 8'h32; in_data3 = 8'h43;
      do_reset();
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 4'b0001) $display("FAIL rot_first_grant: got %b expected 0001", in_ready);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_total++;
         if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== exp_d[i % 4])
            $display("FAIL rot_step%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     i, out_valid, out_sel, out_data, i % 4, exp_d[i % 4]);
         else n_pass++;
         n_total++;
         if (in_ready !== (4'b0001 << ((i + 1) % 4)))
            $display("FAIL rot_ready%0d: got %b expected %b", i, in_ready, 4'b0001 << ((i + 1) % 4));
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      // Continues from rotation: last=0, one more edge gives out_sel=1.
      tick();
      n_total++;
      if (out_sel !== 2'd1 || out_data !== 8'h21)
         $display("FAIL bp_setup: got s=%0d d=%h expected s=1 d=21", out_sel, out_data);
      else n_pass++;
      out_ready = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         n_total++;
         if (in_ready !== 4'b0000) $display("FAIL bp_in_ready%0d: got %b expected 0000", c, in_ready);
         else n_pass++;
         tick();
         n_total++;
         if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h21)
            $display("FAIL bp_hold%0d: got v=%b s=%0d d=%h expected v=1 s=1 d=21", c, out_valid, out_sel, out_data);
         else n_pass++;
      end
      out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 4'b0100) $display("FAIL bp_release_ready: got %b expected 0100", in_ready);
      else n_pass++;
      tick();
      n_total++;
      if (out_sel !== 2'd2 || out_data !== 8'h32)
         $display("FAIL bp_release: got s=%0d d=%h expected s=2 d=32", out_sel, out_data);
      else n_pass++;
   endtask

   task automatic test_wrap_skip();
      logic [1:0] exp_s [3];
      exp_s[0] = 2'd0; exp_s[1] = 2'd3; exp_s[2] = 2'd0;
      in_valid = 4'b0000;
      do_reset();
      in_valid  = 4'b1001;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_total++;
         if (in_ready !== (4'b0001 << exp_s[i]))
            $display("FAIL wrap_ready%0d: got %b expected %b", i, in_ready, 4'b0001 << exp_s[i]);
         else n_pass++;
         tick();
         n_total++;
         if (out_valid !== 1'b1 || out_sel !== exp_s[i])
            $display("FAIL wrap_sel%0d: got v=%b s=%0d expected v=1 s=%0d", i, out_valid, out_sel, exp_s[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 4'b0000;
      do_reset();
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2)
         $display("FAIL mid_setup: got v=%b s=%0d expected v=1 s=2", out_valid, out_sel);
      else n_pass++;
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b expected 0000", in_ready);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", out_valid);
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 4'b0001) $display("FAIL mid_after_ready: got %b expected 0001", in_ready);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h10)
         $display("FAIL mid_after_out: got v=%b s=%0d d=%h expected v=1 s=0 d=10", out_valid, out_sel, out_data);
      else n_pass++;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      in_data0  = 8'h00;
      in_data1  = 8'h00;
      in_data2  = 8'hA5;
      in_data3  = 8'h00;
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_wrap_skip();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_mux_4to1_rr_collector
